// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling with a 2-flop input synchroniser.
// Define UART_RX_PARITY_EN to build an 8E1 receiver with an even-parity check.
module uart_rx #(
  parameter int unsigned CLK_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_dv,
  output logic       rx_frame_err,
  output logic       rx_par_err,
  output logic       rx_busy
);

  localparam logic [15:0] LAST_CNT = 16'(CLK_PER_BIT - 1);
  localparam logic [15:0] HALF_CNT = 16'((CLK_PER_BIT - 1) / 2);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
`endif

  state_t      state, state_next;
  logic        rx_meta, rx_s;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        bit_done, half_done;
  logic        cnt_en, cnt_clr, data_smp, stop_smp;
  logic        par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  assign bit_done  = (clk_cnt == LAST_CNT);
  assign half_done = (clk_cnt == HALF_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!rx_s) state_next = START;
      START:   if (half_done) state_next = rx_s ? IDLE : DATA;
      DATA:
        if (bit_done && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      PARITY:  if (bit_done) state_next = STOP;
`endif
      // Returning to IDLE at mid-stop leaves half a bit to catch the next start edge.
      STOP:    if (bit_done) state_next = rx_s ? IDLE : WAIT_HI;
      WAIT_HI: if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_busy  = (state != IDLE);
    cnt_en   = 1'b0;
    data_smp = 1'b0;
    stop_smp = 1'b0;
    case (state)
      START:   cnt_en = 1'b1;
      DATA: begin
        cnt_en   = 1'b1;
        data_smp = bit_done;
      end
`ifdef UART_RX_PARITY_EN
      PARITY:  cnt_en = 1'b1;
`endif
      STOP: begin
        cnt_en   = 1'b1;
        stop_smp = bit_done;
      end
      default: cnt_en = 1'b0;
    endcase
    cnt_clr = (state_next != state) || bit_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt      <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_dv        <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_dv        <= 1'b0;
      rx_frame_err <= 1'b0;
      if (cnt_clr)     clk_cnt <= '0;
      else if (cnt_en) clk_cnt <= clk_cnt + 16'd1;
      if (state == START) bit_idx <= '0;
      if (data_smp) begin
        shift[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 3'd1;
      end
      // Frame error outranks parity error; only one strobe per frame.
      if (stop_smp) begin
        if (!rx_s) begin
          rx_frame_err <= 1'b1;
        end else if (!par_bad) begin
          rx_dv   <= 1'b1;
          rx_data <= shift;
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad    <= 1'b0;
      rx_par_err <= 1'b0;
    end else begin
      rx_par_err <= 1'b0;
      if (state == START) par_bad <= 1'b0;
      if (state == PARITY && bit_done) par_bad <= rx_s ^ (^shift);
      if (stop_smp && rx_s && par_bad) rx_par_err <= 1'b1;
    end
  end
`else
  assign par_bad    = 1'b0;
  assign rx_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a bit-level serial driver and a queue-based
// expectation model of received bytes, strobe counts and frame latency.
module tb_uart_rx;

  localparam int unsigned C = 100;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME = 11 * C;
  localparam int LAT   = 952 + C;
`else
  localparam int FRAME = 10 * C;
  localparam int LAT   = 952;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_dv, rx_frame_err, rx_par_err, rx_busy;

  always #5 clk = ~clk;

  uart_rx #(.CLK_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial), .rx_data(rx_data),
    .rx_dv(rx_dv), .rx_frame_err(rx_frame_err), .rx_par_err(rx_par_err), .rx_busy(rx_busy)
  );

  int nvec = 0, nerr = 0;
  int cyc = 0;
  int dv_t[$];
  logic [7:0] dv_d[$];
  int fe_n = 0, pe_n = 0, ovl_n = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_dv) begin
      dv_t.push_back(cyc);
      dv_d.push_back(rx_data);
    end
    if (rx_frame_err) fe_n++;
    if (rx_par_err) pe_n++;
    if (int'(rx_dv) + int'(rx_frame_err) + int'(rx_par_err) > 1) ovl_n++;
  end

  task automatic clear_mon();
    dv_t.delete();
    dv_d.delete();
    fe_n = 0; pe_n = 0; ovl_n = 0;
  endtask

  // Caller is aligned on a falling clock edge; returns aligned, line left at stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                            output int fall);
    fall = cyc;
    rx_serial = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (C) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx_serial = (^b) ^ par_flip;
    repeat (C) @(negedge clk);
`else
    if (par_flip) rx_serial = 1'b1;
`endif
    rx_serial = stop_bit;
    repeat (C) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++; if (rx_data !== 8'h00) begin nerr++; $display("FAIL reset_data got %h want 00", rx_data); end
    nvec++; if (rx_dv !== 1'b0) begin nerr++; $display("FAIL reset_dv got %b want 0", rx_dv); end
    nvec++; if (rx_frame_err !== 1'b0) begin nerr++; $display("FAIL reset_fe got %b want 0", rx_frame_err); end
    nvec++; if (rx_par_err !== 1'b0) begin nerr++; $display("FAIL reset_pe got %b want 0", rx_par_err); end
    nvec++; if (rx_busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", rx_busy); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int fall, lat;
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0, fall);
    repeat (20) @(negedge clk);
    last_good = 8'hA5;
    nvec++; if (dv_t.size() !== 1) begin nerr++; $display("FAIL single_count got %0d want 1", dv_t.size()); end
    if (dv_t.size() > 0) begin
      lat = dv_t[0] - fall;
      nvec++; if (lat < LAT - 2 || lat > LAT + 2) begin nerr++; $display("FAIL single_latency got %0d want %0d+/-2", lat, LAT); end
      nvec++; if (dv_d[0] !== 8'hA5) begin nerr++; $display("FAIL single_data got %h want a5", dv_d[0]); end
    end
    nvec++; if (fe_n + pe_n !== 0) begin nerr++; $display("FAIL single_errs got %0d want 0", fe_n + pe_n); end
    nvec++; if (rx_busy !== 1'b0) begin nerr++; $display("FAIL single_idle got %b want 0", rx_busy); end
  endtask

  task automatic test_back_to_back();
    int f0, f1;
    clear_mon();
    send_frame(8'h00, 1'b1, 1'b0, f0);
    send_frame(8'hFF, 1'b1, 1'b0, f1);
    repeat (20) @(negedge clk);
    last_good = 8'hFF;
    nvec++; if (dv_t.size() !== 2) begin nerr++; $display("FAIL b2b_count got %0d want 2", dv_t.size()); end
    if (dv_t.size() == 2) begin
      nvec++; if (dv_t[1] - dv_t[0] !== FRAME) begin nerr++; $display("FAIL b2b_spacing got %0d want %0d", dv_t[1] - dv_t[0], FRAME); end
      nvec++; if (dv_d[0] !== 8'h00) begin nerr++; $display("FAIL b2b_first got %h want 00", dv_d[0]); end
      nvec++; if (dv_d[1] !== 8'hFF) begin nerr++; $display("FAIL b2b_second got %h want ff", dv_d[1]); end
    end
  endtask

  task automatic test_glitch();
    int drop;
    logic mid_busy;
    clear_mon();
    rx_serial = 1'b0;
    repeat (20) @(negedge clk);
    mid_busy = rx_busy;
    repeat (10) @(negedge clk);
    rx_serial = 1'b1;
    drop = -1;
    for (int i = 1; i <= 60 && drop < 0; i++) begin
      @(negedge clk);
      if (!rx_busy) drop = i;
    end
    repeat (2 * C) @(negedge clk);
    nvec++; if (mid_busy !== 1'b1) begin nerr++; $display("FAIL glitch_busy got %b want 1", mid_busy); end
    nvec++; if (drop < 0 || drop > 52) begin nerr++; $display("FAIL glitch_drop got %0d want 1..52", drop); end
    nvec++; if (dv_t.size() + fe_n + pe_n !== 0) begin nerr++; $display("FAIL glitch_strobes got %0d want 0", dv_t.size() + fe_n + pe_n); end
  endtask

  task automatic test_frame_err();
    int fall;
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0, fall);
    repeat (2000 - C) @(negedge clk);
    nvec++; if (fe_n !== 1) begin nerr++; $display("FAIL fe_count got %0d want 1", fe_n); end
    nvec++; if (dv_t.size() !== 0) begin nerr++; $display("FAIL fe_nodv got %0d want 0", dv_t.size()); end
    nvec++; if (rx_data !== last_good) begin nerr++; $display("FAIL fe_hold got %h want %h", rx_data, last_good); end
    nvec++; if (rx_busy !== 1'b1) begin nerr++; $display("FAIL fe_waithi got %b want 1", rx_busy); end
    rx_serial = 1'b1;
    repeat (10) @(negedge clk);
    nvec++; if (rx_busy !== 1'b0) begin nerr++; $display("FAIL fe_release got %b want 0", rx_busy); end
    clear_mon();
    send_frame(8'h96, 1'b1, 1'b0, fall);
    repeat (20) @(negedge clk);
    last_good = 8'h96;
    nvec++; if (dv_d.size() !== 1 || dv_d[0] !== 8'h96) begin nerr++; $display("FAIL fe_recover got %0d strobes want one of 96", dv_d.size()); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h5A;
    clear_mon();
    rx_serial = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_serial = b[i];
      repeat (C) @(negedge clk);
    end
    rx_serial = b[4];
    repeat (C / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++; if (rx_data !== 8'h00) begin nerr++; $display("FAIL rstmid_data got %h want 00", rx_data); end
    nvec++; if (rx_busy !== 1'b0) begin nerr++; $display("FAIL rstmid_busy got %b want 0", rx_busy); end
    rx_serial = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * C) @(negedge clk);
    nvec++; if (dv_t.size() + fe_n + pe_n !== 0) begin nerr++; $display("FAIL rstmid_strobes got %0d want 0", dv_t.size() + fe_n + pe_n); end
    clear_mon();
    begin
      int fall;
      send_frame(8'hC3, 1'b1, 1'b0, fall);
    end
    repeat (20) @(negedge clk);
    last_good = 8'hC3;
    nvec++; if (dv_d.size() !== 1 || dv_d[0] !== 8'hC3) begin nerr++; $display("FAIL rstmid_next got %0d strobes want one of c3", dv_d.size()); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int fall_q[$];
    int fall, lat;
    logic [7:0] b;
    clear_mon();
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0, fall);
      exp_q.push_back(b);
      fall_q.push_back(fall);
      repeat ($urandom_range(0, 150)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    last_good = exp_q[$];
    nvec++; if (dv_d.size() !== exp_q.size()) begin nerr++; $display("FAIL rand_count got %0d want %0d", dv_d.size(), exp_q.size()); end
    for (int n = 0; n < exp_q.size() && n < dv_d.size(); n++) begin
      lat = dv_t[n] - fall_q[n];
      nvec++; if (dv_d[n] !== exp_q[n]) begin nerr++; $display("FAIL rand_data[%0d] got %h want %h", n, dv_d[n], exp_q[n]); end
      nvec++; if (lat < LAT - 2 || lat > LAT + 2) begin nerr++; $display("FAIL rand_latency[%0d] got %0d want %0d+/-2", n, lat, LAT); end
    end
    nvec++; if (fe_n + pe_n + ovl_n !== 0) begin nerr++; $display("FAIL rand_errs got %0d want 0", fe_n + pe_n + ovl_n); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int fall;
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0, fall);
    repeat (20) @(negedge clk);
    nvec++; if (dv_d.size() !== 1 || dv_d[0] !== 8'h07 || pe_n !== 0) begin nerr++; $display("FAIL par_good got dv=%0d pe=%0d want dv=1 pe=0", dv_d.size(), pe_n); end
    last_good = 8'h07;
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1, fall);
    repeat (20) @(negedge clk);
    nvec++; if (pe_n !== 1 || dv_d.size() !== 0) begin nerr++; $display("FAIL par_bad got pe=%0d dv=%0d want pe=1 dv=0", pe_n, dv_d.size()); end
    nvec++; if (rx_data !== last_good) begin nerr++; $display("FAIL par_hold got %h want %h", rx_data, last_good); end
  endtask
`endif

  task automatic test_exclusive();
    nvec++; if (ovl_n !== 0) begin nerr++; $display("FAIL strobe_overlap got %0d want 0", ovl_n); end
  endtask

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
